// File: rtl/mem_dump_streamer.sv
// Readback engine: after the core halts, streams word_count memory words from base_addr
// out over a valid/ready channel, each word tagged with its address.
module mem_dump_streamer #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 11
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              halted,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [2:0]        fsm_state
);

   // Stream handshake: a word moves on a cycle where out_valid and out_ready are both
   // high at posedge clk1; once raised, out_valid/data/addr/last hold until that cycle.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_SEND    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] remaining;

   assign fsm_state = state;

   // mem_addr doubles as the running dump address; it advances on every handshake.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state     <= S_IDLE;
         remaining <= '0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (abort && (state != S_IDLE)) begin
         state     <= S_IDLE;
         mem_rd_en <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start && halted) begin
                  busy <= 1'b1;
                  if (word_count == '0) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     remaining <= word_count;
                     mem_addr  <= base_addr;
                     mem_rd_en <= 1'b1;
                     state     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               mem_rd_en <= 1'b0;
               state     <= S_CAPTURE;
            end
            S_CAPTURE: begin
               out_data  <= mem_rdata;
               out_addr  <= mem_addr;
               out_valid <= 1'b1;
               out_last  <= (remaining == CNT_W'(1));
               state     <= S_SEND;
            end
            S_SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  remaining <= remaining - CNT_W'(1);
                  mem_addr  <= mem_addr + ADDR_W'(1);
                  if (remaining != CNT_W'(1)) begin
                     mem_rd_en <= 1'b1;
                     state     <= S_ISSUE;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               mem_rd_en <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: behavioural 1-cycle-latency memory, a negedge
// monitor that records every transferred word, and hand-computed expected streams.
module tb_mem_dump_streamer;

   logic        clk1 = 1'b0;
   logic        rst = 1'b1;
   logic        halted = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] word_count = '0;
   logic        abort = 1'b0;
   logic        mem_rd_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [9:0]  out_addr;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [2:0]  fsm_state;

   mem_dump_streamer #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) dut (
      .clk1(clk1), .rst(rst), .halted(halted), .start(start),
      .base_addr(base_addr), .word_count(word_count), .abort(abort),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
      .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk1 = ~clk1;

   logic [31:0] mem [1024];
   always @(posedge clk1) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   // scoreboard: entries are {last, addr, data}
   logic [42:0] exp_q[$];
   logic [42:0] got_q[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0, done_cnt = 0, rd_cnt = 0, busy_cnt = 0, hs_cyc = 0, done_cyc = 0;
   int stab_err = 0;
   int ready_mode = 0;
   bit prev_stall = 0;
   logic [42:0] prev_word;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [42:0] ent(input bit last, input logic [9:0] a, input logic [31:0] d);
      return {last, a, d};
   endfunction

   always @(negedge clk1) begin
      cyc++;
      if (out_valid && out_ready && !abort && !rst) begin
         got_q.push_back({out_last, out_addr, out_data});
         hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (mem_rd_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (prev_stall && out_valid && ({out_last, out_addr, out_data} != prev_word)) stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_addr, out_data};
   end

   // ready driver: 0 -> always 1, 1 -> toggling with a 10-cycle hold low, 2 -> always 0
   initial begin
      int rcnt;
      rcnt = 0;
      forever begin
         @(posedge clk1);
         #1;
         rcnt++;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rcnt >= 4 && rcnt < 14) ? 1'b0 : ~rcnt[0];
            default: out_ready = 1'b0;
         endcase
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk1);
         #1;
      end
   endtask

   task automatic start_dump(input logic [9:0] b, input logic [10:0] c, input logic h);
      @(posedge clk1);
      #1;
      start = 1'b1; base_addr = b; word_count = c; halted = h;
      @(posedge clk1);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      int d0;
      n = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk1);
         n++;
      end
      check({tag, "_done_seen"}, done_cnt != d0, 1);
      tick(2);
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic push_s1_expect();
      exp_q.push_back(ent(1'b0, 10'd198, 32'd120));
      exp_q.push_back(ent(1'b0, 10'd199, 32'd7));
      exp_q.push_back(ent(1'b1, 10'd200, 32'd5));
   endtask

   initial begin
      int n;
      int d0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 + i;
      mem[198] = 32'd120; mem[199] = 32'd7; mem[200] = 32'd5;
      mem[1022] = 32'hAAAA_0001; mem[1023] = 32'hBBBB_0002;
      mem[0] = 32'hCCCC_0003; mem[1] = 32'hDDDD_0004;

      tick(3);
      check("rst_outputs", {mem_rd_en, out_valid, out_last, busy, done}, 5'b0);
      check("rst_addr_data", {mem_addr, out_addr, out_data}, 52'h0);
      check("rst_state", fsm_state, 3'd0);
      rst = 1'b0;
      tick(2);

      // 1: basic dump with ready held high, latency checks on the first word
      ready_mode = 0;
      push_s1_expect();
      start_dump(10'd198, 11'd3, 1'b1);
      check("s1_rd_en_t1", {mem_rd_en, mem_addr}, {1'b1, 10'd198});
      check("s1_busy", busy, 1'b1);
      tick(1);
      check("s1_capture", {mem_rd_en, out_valid}, 2'b00);
      tick(1);
      check("s1_first_word_t3", {out_valid, out_addr, out_data}, {1'b1, 10'd198, 32'd120});
      wait_done("s1", 40);
      compare_stream("s1");
      check("s1_done_latency", done_cyc - hs_cyc, 1);
      check("s1_idle_after", {busy, done}, 2'b00);

      // 2: same dump under back-pressure
      ready_mode = 1;
      push_s1_expect();
      stab_err = 0;
      start_dump(10'd198, 11'd3, 1'b1);
      wait_done("s2", 120);
      compare_stream("s2");
      check("s2_stable_while_stalled", stab_err, 0);
      ready_mode = 0;

      // 3: zero-length dump, then start while not halted
      rd_cnt = 0; busy_cnt = 0; d0 = done_cnt;
      start_dump(10'd5, 11'd0, 1'b1);
      tick(4);
      check("s3_zero_rd", rd_cnt, 0);
      check("s3_zero_busy_cycles", busy_cnt, 1);
      check("s3_zero_done", done_cnt - d0, 1);
      compare_stream("s3");
      busy_cnt = 0; d0 = done_cnt;
      start_dump(10'd198, 11'd3, 1'b0);
      tick(6);
      check("s3_not_halted_busy", busy_cnt, 0);
      check("s3_not_halted_done", done_cnt - d0, 0);

      // 4: address wrap at top of memory
      exp_q.push_back(ent(1'b0, 10'd1022, 32'hAAAA_0001));
      exp_q.push_back(ent(1'b0, 10'd1023, 32'hBBBB_0002));
      exp_q.push_back(ent(1'b0, 10'd0,    32'hCCCC_0003));
      exp_q.push_back(ent(1'b1, 10'd1,    32'hDDDD_0004));
      start_dump(10'd1022, 11'd4, 1'b1);
      wait_done("s4", 60);
      compare_stream("s4");

      // 5a: start re-asserted mid-dump is ignored
      push_s1_expect();
      start_dump(10'd198, 11'd3, 1'b1);
      tick(2);
      start_dump(10'd0, 11'd5, 1'b1);
      wait_done("s5a", 60);
      compare_stream("s5a");

      // 5b: abort while a word is offered, colliding with a handshake
      ready_mode = 2;
      d0 = done_cnt;
      start_dump(10'd198, 11'd3, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         tick(1);
         n++;
      end
      check("s5b_in_send", out_valid, 1'b1);
      ready_mode = 0;
      out_ready = 1'b1;
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("s5b_abort_idle", {out_valid, busy, fsm_state}, 5'b0);
      tick(6);
      check("s5b_no_done", done_cnt - d0, 0);
      compare_stream("s5b");
      push_s1_expect();
      start_dump(10'd198, 11'd3, 1'b1);
      wait_done("s5c", 60);
      compare_stream("s5c");

      // 6: reset during CAPTURE, then redo the basic dump
      d0 = done_cnt;
      start_dump(10'd198, 11'd3, 1'b1);
      tick(1);
      check("s6_in_capture", fsm_state, 3'd2);
      rst = 1'b1;
      tick(1);
      check("s6_rst_outputs", {mem_rd_en, out_valid, out_last, busy, done}, 5'b0);
      check("s6_rst_addr_data", {mem_addr, out_addr, out_data}, 52'h0);
      rst = 1'b0;
      tick(3);
      check("s6_no_done", done_cnt - d0, 0);
      got_q.delete();
      push_s1_expect();
      start_dump(10'd198, 11'd3, 1'b1);
      wait_done("s6", 60);
      compare_stream("s6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
